// File: rtl/wb_arbiter_pkg.sv
// Shared constants and state encoding for the write-back arbiter.
package wb_arbiter_pkg;

  localparam int WORD_LENGTH    = 32;
  localparam int DEFAULT_ADDR_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first set request
// found scanning upward from ptr, wrapping at N_REQ-1.
module rr_pick
  import wb_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: N_REQ requesters share one registered register-file write port.
// Define WB_ARB_PRIORITY_EN to give requester 0 fixed priority over the round-robin group.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int n      = WORD_LENGTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*n-1:0]      req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    wr_stall,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [n-1:0]            wr_data
);

  localparam int PTR_W = $clog2(N_REQ);

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [N_REQ-1:0]   pick;
  logic               slot_free;
  logic               accept;
  logic [PTR_W-1:0]   win_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [n-1:0]       sel_data;

`ifdef WB_ARB_PRIORITY_EN
  logic [N_REQ-1:0] rr_req;
  logic [N_REQ-1:0] rr_grant;

  // Requester 0 is excluded from the rotation and overrides it when valid.
  assign rr_req = {req_valid[N_REQ-1:1], 1'b0};

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req   (rr_req),
    .ptr   (rr_ptr),
    .grant (rr_grant)
  );

  assign pick = req_valid[0] ? N_REQ'(1) : rr_grant;
`else
  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick)
  );
`endif

  assign slot_free = (state == IDLE) || !wr_stall;
  assign accept    = |req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (accept) state_nxt = ISSUE;
               else if (!wr_stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (rst_n && slot_free) ? pick : '0;
    wr_en     = (state == ISSUE);
  end

  // Winner index and its payload, selected from the one-hot grant.
  always_comb begin
    win_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        win_idx  = PTR_W'(i);
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*n +: n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr <= '0;
      wr_data <= '0;
    end else if (accept) begin
      wr_addr <= sel_addr;
      wr_data <= sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
`ifdef WB_ARB_PRIORITY_EN
      if (!req_ready[0])
        rr_ptr <= (int'(win_idx) == N_REQ-1) ? '0 : win_idx + PTR_W'(1);
`else
      rr_ptr <= (int'(win_idx) == N_REQ-1) ? '0 : win_idx + PTR_W'(1);
`endif
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a behavioural model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              wr_stall;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;

  logic [AW-1:0] raddr [NR];
  logic [DW-1:0] rdata [NR];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = raddr[i];
      req_data[i*DW +: DW] = rdata[i];
    end
  end

  wb_arbiter #(.N_REQ(NR), .n(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_stall  (wr_stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: one output slot, a rotation pointer, and the slot contents.
  bit            m_full;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_ptr;
  int            m_win;

  function automatic int model_winner(input logic [NR-1:0] v, input int ptr);
    logic [NR-1:0] c;
    c = v;
`ifdef WB_ARB_PRIORITY_EN
    if (v[0]) return 0;
    c[0] = 1'b0;
`endif
    for (int k = 0; k < NR; k++) begin
      if (c[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [NR-1:0] v, input logic s,
                      output logic [NR-1:0] g_ready, output logic g_en,
                      output logic [AW-1:0] g_addr, output logic [DW-1:0] g_data);
    rst_n     = r;
    req_valid = v;
    wr_stall  = s;
    #1;
    m_win = -1;
    if (r && (!m_full || !s)) m_win = model_winner(v, m_ptr);
    g_ready = req_ready;
    check("ready", 32'(req_ready), (m_win < 0) ? 32'd0 : (32'd1 << m_win));
    @(posedge clk);
    #1;
    if (!r) begin
      m_full = 1'b0; m_addr = '0; m_data = '0; m_ptr = 0;
    end else if (m_win >= 0) begin
      m_full = 1'b1;
      m_addr = raddr[m_win];
      m_data = rdata[m_win];
`ifdef WB_ARB_PRIORITY_EN
      if (m_win != 0) m_ptr = (m_win + 1) % NR;
`else
      m_ptr = (m_win + 1) % NR;
`endif
    end else if (!s) begin
      m_full = 1'b0;
    end
    g_en   = wr_en;
    g_addr = wr_addr;
    g_data = wr_data;
    check("wr_en",   32'(wr_en),   32'(m_full));
    check("wr_addr", 32'(wr_addr), 32'(m_addr));
    check("wr_data", wr_data,      m_data);
    @(negedge clk);
  endtask

  typedef struct {
    logic          r;
    logic [NR-1:0] v;
    logic          s;
    logic [NR-1:0] er;
    logic          ee;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[$];

  logic [NR-1:0] g_ready;
  logic          g_en;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_data;
  int            held;
  logic [NR-1:0] rv;
  logic          rr, rs;

  initial begin
    rst_n = 1'b0; req_valid = '0; wr_stall = 1'b0;
    m_full = 1'b0; m_addr = '0; m_data = '0; m_ptr = 0; m_win = -1;
    for (int i = 0; i < NR; i++) begin
      raddr[i] = AW'(10 + i);
      rdata[i] = 32'hC0DE_0000 + 32'(i);
    end
    @(negedge clk);

`ifndef WB_ARB_PRIORITY_EN
    tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 5'd0,  32'd0});
    tbl.push_back('{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 5'd0,  32'd0});
    tbl.push_back('{1'b1, 4'hF, 1'b0, 4'h1, 1'b1, 5'd10, 32'hC0DE_0000});
    tbl.push_back('{1'b1, 4'hF, 1'b0, 4'h2, 1'b1, 5'd11, 32'hC0DE_0001});
    tbl.push_back('{1'b1, 4'hF, 1'b0, 4'h4, 1'b1, 5'd12, 32'hC0DE_0002});
    tbl.push_back('{1'b1, 4'hF, 1'b0, 4'h8, 1'b1, 5'd13, 32'hC0DE_0003});
    tbl.push_back('{1'b1, 4'hF, 1'b0, 4'h1, 1'b1, 5'd10, 32'hC0DE_0000});
    tbl.push_back('{1'b1, 4'hF, 1'b0, 4'h2, 1'b1, 5'd11, 32'hC0DE_0001});
    tbl.push_back('{1'b1, 4'hF, 1'b0, 4'h4, 1'b1, 5'd12, 32'hC0DE_0002});
    tbl.push_back('{1'b1, 4'hF, 1'b0, 4'h8, 1'b1, 5'd13, 32'hC0DE_0003});
    tbl.push_back('{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 5'd13, 32'hC0DE_0003});
    tbl.push_back('{1'b1, 4'h4, 1'b0, 4'h4, 1'b1, 5'd12, 32'hC0DE_0002});
    tbl.push_back('{1'b1, 4'h9, 1'b0, 4'h8, 1'b1, 5'd13, 32'hC0DE_0003});
    tbl.push_back('{1'b1, 4'h1, 1'b0, 4'h1, 1'b1, 5'd10, 32'hC0DE_0000});
    tbl.push_back('{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 5'd10, 32'hC0DE_0000});
    tbl.push_back('{1'b1, 4'h2, 1'b0, 4'h2, 1'b1, 5'd11, 32'hC0DE_0001});
    tbl.push_back('{1'b1, 4'h2, 1'b1, 4'h0, 1'b1, 5'd11, 32'hC0DE_0001});
    tbl.push_back('{1'b1, 4'h2, 1'b0, 4'h2, 1'b1, 5'd11, 32'hC0DE_0001});
    tbl.push_back('{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 5'd11, 32'hC0DE_0001});
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].s, g_ready, g_en, g_addr, g_data);
      check($sformatf("tbl%0d_ready", i), 32'(g_ready), 32'(tbl[i].er));
      check($sformatf("tbl%0d_en", i),    32'(g_en),    32'(tbl[i].ee));
      check($sformatf("tbl%0d_addr", i),  32'(g_addr),  32'(tbl[i].ea));
      check($sformatf("tbl%0d_data", i),  g_data,       tbl[i].ed);
    end
`endif

    // Stalled write is held for four cycles and then consumed exactly once.
    step(1'b0, 4'h0, 1'b0, g_ready, g_en, g_addr, g_data);
    raddr[2] = 5'd5;
    rdata[2] = 32'hDEAD_BEEF;
    held = 0;
    step(1'b1, 4'h4, 1'b0, g_ready, g_en, g_addr, g_data);
    check("stall_accept", 32'(g_ready), 32'h4);
    if (g_en && g_addr == 5'd5 && g_data == 32'hDEAD_BEEF) held++;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 4'h2, 1'b1, g_ready, g_en, g_addr, g_data);
      check("stall_ready", 32'(g_ready), 32'h0);
      if (g_en && g_addr == 5'd5 && g_data == 32'hDEAD_BEEF) held++;
    end
    step(1'b1, 4'h2, 1'b0, g_ready, g_en, g_addr, g_data);
    check("stall_held", 32'(held), 32'd4);
    check("stall_next", 32'(g_addr), 32'(raddr[1]));
    step(1'b1, 4'h0, 1'b0, g_ready, g_en, g_addr, g_data);

    // Reset while a stalled write is pending.
    step(1'b1, 4'h1, 1'b0, g_ready, g_en, g_addr, g_data);
    step(1'b1, 4'h2, 1'b1, g_ready, g_en, g_addr, g_data);
    step(1'b0, 4'h2, 1'b1, g_ready, g_en, g_addr, g_data);
    check("rst_ready", 32'(g_ready), 32'h0);
    check("rst_en",    32'(g_en),    32'h0);
    check("rst_addr",  32'(g_addr),  32'h0);
    step(1'b1, 4'h0, 1'b0, g_ready, g_en, g_addr, g_data);
    check("rst_no_issue", 32'(g_en), 32'h0);
    step(1'b1, 4'hF, 1'b0, g_ready, g_en, g_addr, g_data);
    check("rst_ptr", 32'(g_ready), 32'h1);
    step(1'b1, 4'h0, 1'b0, g_ready, g_en, g_addr, g_data);

`ifdef WB_ARB_PRIORITY_EN
    step(1'b0, 4'h0, 1'b0, g_ready, g_en, g_addr, g_data);
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 4'hB, 1'b0, g_ready, g_en, g_addr, g_data);
      check("prio_zero", 32'(g_ready), 32'h1);
    end
    step(1'b1, 4'hA, 1'b0, g_ready, g_en, g_addr, g_data);
    check("prio_one", 32'(g_ready), 32'h2);
    step(1'b1, 4'hA, 1'b0, g_ready, g_en, g_addr, g_data);
    check("prio_three", 32'(g_ready), 32'h8);
`endif

    // Randomized traffic: requests stay stable until accepted.
    rv = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i]    = 1'b1;
          raddr[i] = AW'($urandom);
          rdata[i] = $urandom;
        end
      end
      rr = ($urandom_range(0, 49) != 0);
      rs = ($urandom_range(0, 3) == 0);
      step(rr, rv, rs, g_ready, g_en, g_addr, g_data);
      if (m_win >= 0) rv[m_win] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
